// File: rtl/sub_shift_rows_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_shift_rows_pkg
// Description : Shared state encoding and byte-position helper for the
//               iterative SubBytes + ShiftRows stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_shift_rows_pkg;

    localparam int c_state_w = 2;

    // Only two encodings are used; the remaining ones fall back to IDLE.
    typedef enum logic [c_state_w-1:0] {
        IDLE = 2'd0,
        COL  = 2'd1
    } state_t;

    // MSB position of byte (row, col) in a row-major 128-bit AES state.
    function automatic logic [6:0] byte_msb(input logic [1:0] row,
                                            input logic [1:0] col);
        return 7'd127 - {row, 5'b00000} - 7'({col, 3'b000});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_shift_rows_sbox.sv
`default_nettype none
// ============================================================================
// Module      : enc_word_sbox
// Description : Combinational 32-bit word substitution: four parallel
//               forward AES S-box lookups. Usable by key expansion as well.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_word_sbox (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit 8*(255-x); for an 8-bit x, 255-x is simply ~x.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0]  w_in_byte;
        logic [10:0] w_idx;
        assign w_in_byte               = word_in[31-8*i -: 8];
        assign w_idx                   = {~w_in_byte, 3'b000};
        assign word_out[31-8*i -: 8]   = c_sbox_table[w_idx +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/sub_shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : sub_shift_rows
// Description : Iterative AES SubBytes + ShiftRows. Latches a state on start,
//               substitutes one shifted column per cycle through a shared
//               word S-box, then presents the full result with a ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_shift_rows
    import sub_shift_rows_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         start_in,
    output logic [127:0] data_out,
    output logic         ready_out,
    output logic         busy_out
);

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_col_cnt;
    logic [127:0] r_src;
    logic [127:0] r_work;
    logic [127:0] r_data_out;
    logic         r_ready_out;
    logic         r_busy_out;
    logic         w_accept;
    logic         w_last;
    logic [31:0]  w_sbox_in;
    logic [31:0]  w_sbox_out;
    logic [127:0] w_work_merged;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state decode plus accept / final-column strobes.
    always_comb begin
        w_next_state = IDLE;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_accept     = 1'b1;
                    w_next_state = COL;
                end
            end
            COL: begin
                if (r_col_cnt == 2'd3) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = COL;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Gather the diagonal for output column col_cnt: row r reads column col_cnt+r.
    always_comb begin
        w_sbox_in = '0;
        for (int r = 0; r < 4; r++) begin
            w_sbox_in[31-8*r -: 8] = r_src[byte_msb(2'(r), r_col_cnt + 2'(r)) -: 8];
        end
    end

    enc_word_sbox u_sbox (
        .word_in  (w_sbox_in),
        .word_out (w_sbox_out)
    );

    // Scatter the substituted word into column col_cnt of the work state.
    always_comb begin
        w_work_merged = r_work;
        for (int r = 0; r < 4; r++) begin
            w_work_merged[byte_msb(2'(r), r_col_cnt) -: 8] = w_sbox_out[31-8*r -: 8];
        end
    end

    // Datapath: latch on accept, build one column per cycle, publish at the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt   <= 2'd0;
            r_src       <= '0;
            r_work      <= '0;
            r_data_out  <= '0;
            r_ready_out <= 1'b0;
            r_busy_out  <= 1'b0;
        end else begin
            r_ready_out <= 1'b0;
            if (w_accept) begin
                r_src      <= data_in;
                r_col_cnt  <= 2'd0;
                r_busy_out <= 1'b1;
            end
            if (r_state == COL) begin
                r_work    <= w_work_merged;
                r_col_cnt <= r_col_cnt + 2'd1;
            end
            // data_out only changes here, so MixColumns never sees a partial state.
            if (w_last) begin
                r_data_out  <= w_work_merged;
                r_ready_out <= 1'b1;
                r_busy_out  <= 1'b0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign ready_out = r_ready_out;
    assign busy_out  = r_busy_out;

endmodule
`default_nettype wire

// File: tb/tb_sub_shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_shift_rows
// Description : Scoreboard bench for sub_shift_rows. The reference S-box is
//               derived from GF(2^8) inversion plus the affine map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_shift_rows;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] data_in = '0;
    logic         start_in = 1'b0;
    logic [127:0] data_out;
    logic         ready_out;
    logic         busy_out;

    int           n_tests = 0;
    int           n_fails = 0;
    int           n_pushed = 0;
    int           n_ready = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   ref_sbox [256];

    sub_shift_rows dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .start_in  (start_in),
        .data_out  (data_out),
        .ready_out (ready_out),
        .busy_out  (busy_out)
    );

    always #5 clk = ~clk;

    // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine transform.
    function automatic logic [7:0] sbox_def(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // out(r,c) = S(in(r,(c+r) mod 4)) on a row-major byte matrix.
    function automatic logic [127:0] model(input logic [127:0] d);
        logic [7:0]   m [4][4];
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = d[127 - 32*r - 8*c -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 32*r - 8*c -: 8] = ref_sbox[m[r][(c + r) % 4]];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse pops one expected result.
    always @(negedge clk) begin
        if (rst && ready_out === 1'b1) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fails++;
                $display("FAIL unexpected_ready: got %h expected no pulse", data_out);
            end else begin
                check("scoreboard_data", data_out, exp_q.pop_front());
            end
        end
    end

    // Issue one block, push its expectation, check latency and busy length.
    task automatic run_block(input logic [127:0] d, input logic [127:0] exp, input string name);
        int  edges = 0;
        int  busy_cnt;
        bit  seen = 0;
        @(negedge clk);
        data_in  = d;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        data_in  = rand128();
        exp_q.push_back(exp);
        n_pushed++;
        busy_cnt = busy_out ? 1 : 0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy_out) busy_cnt++;
            if (ready_out) seen = 1;
        end
        check({name, "_latency"}, 128'(edges), 128'd4);
        check({name, "_busy_cycles"}, 128'(busy_cnt), 128'd4);
    endtask

    initial begin
        logic [127:0] d1, d2, e1;
        int           cnt;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1, d2, e1, e2;
        int           cnt;
        for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_def(8'(i));

        // Reset state
        #12;
        check("reset_data_out", data_out, 128'h0);
        check("reset_ready", 128'(ready_out), 128'd0);
        check("reset_busy", 128'(busy_out), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Known vectors
        run_block(128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08,
                  128'hd4e0b81e_bfb44127_5d521198_30aef1e5, "fips_round1");
        run_block(128'h00010203_04050607_08090a0b_0c0d0e0f,
                  128'h637c777b_6b6fc5f2_672b3001_76fed7ab, "rotation");
        run_block('0, {16{8'h63}}, "all_zero");
        run_block({16{8'hff}}, {16{8'h16}}, "all_ff");

        // Busy protection: second start two cycles after accept is dropped
        d1 = rand128();
        d2 = ~d1;
        @(negedge clk);
        data_in  = d1;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        exp_q.push_back(model(d1));
        n_pushed++;
        @(negedge clk);
        @(negedge clk);
        data_in  = d2;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        data_in  = rand128();
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (ready_out) cnt++;
        end
        check("busy_single_pulse", 128'(cnt), 128'd1);
        check("busy_result_first", data_out, model(d1));

        // Back-to-back with start held high
        d1 = rand128();
        d2 = rand128();
        e1 = model(d1);
        e2 = model(d2);
        @(negedge clk);
        data_in  = d1;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(e1);
        n_pushed++;
        data_in = d2;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                start_in = 1'b0;
                exp_q.push_back(e2);
                n_pushed++;
                data_in = rand128();
            end
            check($sformatf("b2b_ready_n%0d", n), 128'(ready_out), 128'((n == 4) || (n == 9)));
            if (n >= 4 && n < 9) check($sformatf("b2b_hold_n%0d", n), data_out, e1);
        end
        check("b2b_second", data_out, e2);

        // Randomized blocks
        for (int i = 0; i < 8; i++) begin
            d1 = rand128();
            run_block(d1, model(d1), $sformatf("rand%0d", i));
        end

        // Reset during column 2 aborts the block
        @(negedge clk);
        data_in  = rand128();
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_data_out", data_out, 128'h0);
        check("abort_ready", 128'(ready_out), 128'd0);
        check("abort_busy", 128'(busy_out), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (ready_out) cnt++;
        end
        check("abort_no_pulse", 128'(cnt), 128'd0);
        d1 = rand128();
        run_block(d1, model(d1), "after_reset");

        repeat (3) @(posedge clk);
        #1;
        check("ready_total", 128'(n_ready), 128'(n_pushed));
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub_shift_rows.md
# sub_shift_rows

Iterative AES encryption SubBytes + ShiftRows stage, directly upstream of the column-serial MixColumns stage. It accepts a 128-bit state on a start pulse and latches it internally. It then produces one shifted, substituted output column per cycle through a shared 4-byte S-box word unit. It presents the complete 128-bit result with a one-cycle ready pulse that drives MixColumns' start input directly.

## Interface
- Parameters: none.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  128  input state; row-major, byte (r,c) at bits [127-32r-8c -: 8]; sampled only on the accept edge.
- start_in  in  1  request; accepted only when idle.
- data_out  out  128  result state, same layout as data_in; held until the next completion.
- ready_out  out  1  one-cycle pulse, data_out valid; connects to MixColumns start_in.
- busy_out  out  1  high from the accept edge until the completion edge; start_in ignored while high.

## Operation
- Function: out(r,c) = SBOX(in(r,(c+r) mod 4)), where SBOX is the FIPS-197 forward S-box.
- Internal regs:
  - src_reg (128): latched input.
  - work_reg (128): result being assembled.
  - col_cnt (2): column index.
  - state.
- States:
  - IDLE: start_in=1 → src_reg<=data_in, col_cnt<=0, busy_out<=1, next COL.
  - COL: gather bytes src(r,(col_cnt+r) mod 4) for r=0..3 into the S-box word input. Write the S-box word output into work_reg column col_cnt. Then:
    - col_cnt!=3: col_cnt++, stay in COL.
    - col_cnt==3: data_out<=work_reg with column 3 merged in, ready_out<=1, busy_out<=0, next IDLE.
- data_out updates atomically at completion only. There are no partial updates and no glitching toward MixColumns.
- Column index arithmetic is 2-bit and wraps mod 4. No other arithmetic is performed.
- Unused state encodings → IDLE on the next edge. Outputs are held.

## Timing
- Reset values: data_out=0, ready_out=0, busy_out=0, state=IDLE, col_cnt=0, src_reg=0, work_reg=0.
- Latency: start accepted at edge k. Columns 0..3 are written at edges k+1..k+4. ready_out is high in the cycle after edge k+4, and data_out is valid from that cycle.
- Throughput: one block per 5 cycles. The earliest next accept is edge k+5.
- ready_out is high for exactly one cycle per accepted block.
- start_in while busy_out=1 is ignored, not queued. It has no effect on the result.
- start_in held high continuously restarts from IDLE every 5 cycles. Each block uses data_in as sampled on its own accept edge.
- data_in may change freely after the accept edge.
- Reset mid-operation aborts the block: all outputs return to their reset values immediately, there is no ready pulse, and the next start_in after reset release is accepted normally.

## Structure
- Shared package/header:
  - state encodings (IDLE, COL).
  - byte-position helper or constant: bit offset of (r,c) = 127-32r-8c.
- Sub-module enc_word_sbox: combinational, 32 in → 32 out, four parallel forward S-box lookups (256-entry table). It is reusable by key expansion.
- Top contains the FSM, column counter, gather/scatter muxing and output registers.

## Test plan
- FIPS-197 App. B round 1: data_in=128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08, start one cycle → ready_out pulse 5 cycles later (relative to the start cycle), data_out=128'hd4e0b81e_bfb44127_5d521198_30aef1e5.
- Rotation check: data_in=128'h00010203_04050607_08090a0b_0c0d0e0f → data_out=128'h637c777b_6b6fc5f2_672b3001_76fed7ab.
- Uniform inputs: all-zero → 128'h6363…63, all-FF → 128'h1616…16. busy_out is high for exactly 4 cycles in each case.
- Busy protection: pulse start_in again 2 cycles after the accept with different data_in → exactly one ready pulse, result from the first data. Changing data_in after the accept does not alter the result.
- Back-to-back: start_in held high with two vectors → two ready pulses 5 cycles apart, both results correct. The data_out of the first block is stable until the second completes.
- Reset: assert rst during column 2 → data_out=0, ready_out=0 and busy_out=0 asynchronously, no ready pulse. A new start after release completes correctly.
